// File: rtl/controle_cronometro_pkg.sv
// Shared definitions for the stopwatch control stage: run-control state
// encodings and the helper that sizes counters from the block parameters.
package controle_cronometro_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10
    } estadoT;

    // Bits needed to hold any value in 0..maxValor (never less than one).
    function automatic int larguraContador(input int unsigned maxValor);
        return (maxValor < 2) ? 1 : $clog2(maxValor + 1);
    endfunction

endpackage

// File: rtl/controle_cronometro_debounce_botao.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// press pulse on each accepted released->pressed (1->0) transition.
module debounce_botao
    import controle_cronometro_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic pressionado
);

    localparam int CONT_W = larguraContador(DEBOUNCE_CYCLES);
    localparam logic [CONT_W-1:0] CONT_ULTIMO = CONT_W'(DEBOUNCE_CYCLES - 1);

    logic              sinc1;
    logic              sinc2;
    logic              nivelEstavel;
    logic [CONT_W-1:0] contEstavel;

    // Buttons are active-low, so every level starts at the released value 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1        <= 1'b1;
            sinc2        <= 1'b1;
            nivelEstavel <= 1'b1;
            contEstavel  <= '0;
            pressionado  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sinc1 -> sinc2 a real two-flop chain.
            sinc1       <= botao;
            sinc2       <= sinc1;
            pressionado <= 1'b0;
            if (sinc2 == nivelEstavel) begin
                contEstavel <= '0;
            end else if (contEstavel == CONT_ULTIMO) begin
                nivelEstavel <= sinc2;
                contEstavel  <= '0;
                pressionado  <= ~sinc2;
            end else begin
                contEstavel <= contEstavel + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch control stage: debounced buttons, run-control FSM, 1 Hz count
// signal and display scan clock. Define CONTROLE_PISCAR_EN for the pause blink.
module controle_cronometro
    import controle_cronometro_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned SCAN_HZ         = 1_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botaoIniciar,
    input  logic       botaoZerar,
    output logic       umSegundo,
    output logic       displayClock,
    output logic       zerarContagem,
    output logic [1:0] estado,
    output logic       piscar
);

    localparam int DIV_W  = larguraContador(CLK_HZ - 1);
    localparam int SCAN_W = larguraContador(CLK_HZ / (2 * SCAN_HZ) - 1);
    localparam logic [DIV_W-1:0]  DIV_ULTIMO  = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0]  DIV_MEIO    = DIV_W'(CLK_HZ / 2 - 1);
    localparam logic [SCAN_W-1:0] SCAN_ULTIMO = SCAN_W'(CLK_HZ / (2 * SCAN_HZ) - 1);

    logic              eventoIniciar;
    logic              eventoZerar;
    estadoT            estadoAtual;
    estadoT            estadoProx;
    logic [DIV_W-1:0]  div;
    logic [SCAN_W-1:0] contScan;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debIniciar (
        .clock       (clock),
        .reset       (reset),
        .botao       (botaoIniciar),
        .pressionado (eventoIniciar)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debZerar (
        .clock       (clock),
        .reset       (reset),
        .botao       (botaoZerar),
        .pressionado (eventoZerar)
    );

    always_comb begin
        // NOTE: default assignment first so no path leaves estadoProx unassigned (no latch).
        estadoProx = PARADO;
        case (estadoAtual)
            PARADO:   estadoProx = eventoIniciar ? CONTANDO : PARADO;
            CONTANDO: estadoProx = eventoIniciar ? PAUSADO  : CONTANDO;
            PAUSADO:  estadoProx = eventoIniciar ? CONTANDO : PAUSADO;
            default:  estadoProx = PARADO;
        endcase
        // Zero has priority; a simultaneous start/pause press is dropped.
        if (eventoZerar) estadoProx = PARADO;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estadoAtual   <= PARADO;
            zerarContagem <= 1'b0;
        end else begin
            estadoAtual   <= estadoProx;
            zerarContagem <= eventoZerar;
        end
    end

    assign estado = estadoAtual;

    // Second divider only advances while counting, so a pause keeps the partial second.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div       <= '0;
            umSegundo <= 1'b0;
        end else if (eventoZerar) begin
            div       <= '0;
            umSegundo <= 1'b0;
        end else if (estadoAtual == CONTANDO) begin
            if (div == DIV_ULTIMO) begin
                div       <= '0;
                umSegundo <= 1'b1;
            end else begin
                div <= div + 1'b1;
                if (div == DIV_MEIO) umSegundo <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contScan     <= '0;
            displayClock <= 1'b0;
        end else if (contScan == SCAN_ULTIMO) begin
            contScan     <= '0;
            displayClock <= ~displayClock;
        end else begin
            contScan <= contScan + 1'b1;
        end
    end

`ifdef CONTROLE_PISCAR_EN
    localparam int PISCA_W = larguraContador(CLK_HZ / 4 - 1);
    localparam logic [PISCA_W-1:0] PISCA_ULTIMO = PISCA_W'(CLK_HZ / 4 - 1);

    logic [PISCA_W-1:0] contPisca;

    // Blink restarts high on every entry to PAUSADO and is forced low elsewhere.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contPisca <= '0;
            piscar    <= 1'b0;
        end else if (estadoProx != PAUSADO) begin
            contPisca <= '0;
            piscar    <= 1'b0;
        end else if (estadoAtual != PAUSADO) begin
            contPisca <= '0;
            piscar    <= 1'b1;
        end else if (contPisca == PISCA_ULTIMO) begin
            contPisca <= '0;
            piscar    <= ~piscar;
        end else begin
            contPisca <= contPisca + 1'b1;
        end
    end
`else
    assign piscar = 1'b0;
`endif

endmodule

// File: tb/tb_controle_cronometro.sv
// Self-checking bench for controle_cronometro with small clock/debounce parameters.
module tb_controle_cronometro;

    localparam int CLK_HZ    = 20;
    localparam int SCAN_HZ   = 5;
    localparam int DEB       = 4;
    localparam int MEIO_SCAN = CLK_HZ / (2 * SCAN_HZ);
    localparam logic [1:0] EST_PARADO   = 2'b00;
    localparam logic [1:0] EST_CONTANDO = 2'b01;
    localparam logic [1:0] EST_PAUSADO  = 2'b10;

    logic       clock = 1'b0;
    logic       reset;
    logic       botaoIniciar;
    logic       botaoZerar;
    logic       umSegundo;
    logic       displayClock;
    logic       zerarContagem;
    logic [1:0] estado;
    logic       piscar;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int zeroPulses = 0;
    logic zPrev = 1'b0;

    typedef struct {
        string      nome;
        logic       ini;
        logic       zer;
        int         ciclos;
        logic [1:0] estadoEsp;
        int         pulsosEsp;
    } vetorT;

    vetorT tabela[$];

    controle_cronometro #(
        .CLK_HZ          (CLK_HZ),
        .SCAN_HZ         (SCAN_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botaoIniciar  (botaoIniciar),
        .botaoZerar    (botaoZerar),
        .umSegundo     (umSegundo),
        .displayClock  (displayClock),
        .zerarContagem (zerarContagem),
        .estado        (estado),
        .piscar        (piscar)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nome, cyc, atual, esperado);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic addVetor(input string n, input logic i, input logic z, input int c,
                            input logic [1:0] e, input int p);
        vetorT v;
        v.nome = n; v.ini = i; v.zer = z; v.ciclos = c; v.estadoEsp = e; v.pulsosEsp = p;
        tabela.push_back(v);
    endtask

    // t = number of clock edges spent counting since the last clear.
    function automatic logic umEsperado(input int t);
        return (t >= CLK_HZ) && (((t - CLK_HZ) % CLK_HZ) < CLK_HZ / 2);
    endfunction

    function automatic logic piscarEsperado(input int d);
`ifdef CONTROLE_PISCAR_EN
        return ((d / (CLK_HZ / 4)) % 2) == 0;
`else
        return (d < 0);
`endif
    endfunction

    // zerarContagem must be a single-cycle pulse; also count pulses.
    always @(negedge clock) begin
        if (reset) begin
            zPrev = 1'b0;
        end else begin
            if (zerarContagem) begin
                zeroPulses++;
                check("zerarContagem width", 32'(zPrev), 32'(1'b0));
            end
            zPrev = zerarContagem;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, p1, r1, z1, e2, pulsos;

        reset = 1'b1; botaoIniciar = 1'b1; botaoZerar = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset estado", 32'(estado), 32'(EST_PARADO));
        check("reset umSegundo", 32'(umSegundo), 32'(1'b0));
        check("reset displayClock", 32'(displayClock), 32'(1'b0));
        check("reset zerarContagem", 32'(zerarContagem), 32'(1'b0));
        check("reset piscar", 32'(piscar), 32'(1'b0));
        reset = 1'b0;
        cyc = 0;

        // Idle: only the scan clock moves.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("displayClock idle", 32'(displayClock), 32'((cyc / MEIO_SCAN) % 2));
        end
        check("idle estado", 32'(estado), 32'(EST_PARADO));
        check("idle umSegundo", 32'(umSegundo), 32'(1'b0));

        // Glitch shorter than the debounce window.
        botaoIniciar = 1'b0;
        repeat (3) tick();
        botaoIniciar = 1'b1;
        repeat (10) tick();
        check("glitch estado", 32'(estado), 32'(EST_PARADO));

        // Start: state changes exactly 7 cycles after the raw press.
        botaoIniciar = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("start latency estado", 32'(estado), 32'((i == 7) ? EST_CONTANDO : EST_PARADO));
        end
        e1 = cyc;
        while (cyc < e1 + 61) begin
            tick();
            if (cyc == e1 + 3) botaoIniciar = 1'b1;
            check("umSegundo counting", 32'(umSegundo), 32'(umEsperado(cyc - e1)));
        end

        // Pause press seen by the FSM while div==7; the partial second freezes.
        botaoIniciar = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("pause latency estado", 32'(estado), 32'((i == 7) ? EST_PAUSADO : EST_CONTANDO));
            check("umSegundo before pause", 32'(umSegundo), 32'(umEsperado(cyc - e1)));
        end
        p1 = cyc;
        check("piscar on pause entry", 32'(piscar), 32'(piscarEsperado(0)));
        while (cyc < e1 + 100) begin
            tick();
            if (cyc == e1 + 71) botaoIniciar = 1'b1;
            check("paused estado", 32'(estado), 32'(EST_PAUSADO));
            check("umSegundo frozen", 32'(umSegundo), 32'(umEsperado(68)));
            check("piscar paused", 32'(piscar), 32'(piscarEsperado(cyc - p1)));
        end

        // Resume.
        botaoIniciar = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("resume latency estado", 32'(estado), 32'((i == 7) ? EST_CONTANDO : EST_PAUSADO));
            check("piscar around resume", 32'(piscar), 32'((i == 7) ? 1'b0 : piscarEsperado(cyc - p1)));
        end
        r1 = cyc;
        while (cyc < r1 + 30) begin
            tick();
            if (cyc == r1 + 3) botaoIniciar = 1'b1;
            check("umSegundo after resume", 32'(umSegundo), 32'(umEsperado(68 + cyc - r1)));
            check("piscar running", 32'(piscar), 32'(1'b0));
        end

        // Both buttons together while counting: zero wins.
        pulsos = zeroPulses;
        botaoIniciar = 1'b0;
        botaoZerar = 1'b0;
        z1 = cyc;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("simultaneous estado", 32'(estado), 32'((i >= 7) ? EST_PARADO : EST_CONTANDO));
            check("simultaneous umSegundo", 32'(umSegundo), 32'((i >= 7) ? 1'b0 : umEsperado(68 + cyc - r1)));
            check("simultaneous zerarContagem", 32'(zerarContagem), 32'(i == 7));
        end
        while (cyc < z1 + 30) begin
            tick();
            if (cyc == z1 + 10) begin
                botaoIniciar = 1'b1;
                botaoZerar = 1'b1;
            end
        end
        check("simultaneous estado settled", 32'(estado), 32'(EST_PARADO));
        check("simultaneous pulse count", 32'(zeroPulses - pulsos), 32'(1));

        // Restart: the cleared divider gives a full second before the first rise.
        botaoIniciar = 1'b0;
        repeat (7) tick();
        check("restart estado", 32'(estado), 32'(EST_CONTANDO));
        e2 = cyc;
        while (cyc < e2 + 25) begin
            tick();
            if (cyc == e2 + 3) botaoIniciar = 1'b1;
            check("umSegundo after zero", 32'(umSegundo), 32'(umEsperado(cyc - e2)));
        end

        // Asynchronous reset mid-count, no clock edge needed.
        pulsos = zeroPulses;
        #3 reset = 1'b1;
        #1;
        check("async reset estado", 32'(estado), 32'(EST_PARADO));
        check("async reset umSegundo", 32'(umSegundo), 32'(1'b0));
        check("async reset displayClock", 32'(displayClock), 32'(1'b0));
        check("async reset zerarContagem", 32'(zerarContagem), 32'(1'b0));
        check("async reset piscar", 32'(piscar), 32'(1'b0));
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) tick();
        check("post reset estado", 32'(estado), 32'(EST_PARADO));
        check("post reset no zero pulse", 32'(zeroPulses - pulsos), 32'(0));

        // Directed button vectors from PARADO.
        addVetor("start",         1'b0, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("release",       1'b1, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("glitch run",    1'b0, 1'b1,  3, EST_CONTANDO, 0);
        addVetor("after glitch",  1'b1, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("pause",         1'b0, 1'b1, 10, EST_PAUSADO,  0);
        addVetor("release",       1'b1, 1'b1, 10, EST_PAUSADO,  0);
        addVetor("resume",        1'b0, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("release",       1'b1, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("zero running",  1'b1, 1'b0, 10, EST_PARADO,   1);
        addVetor("release zero",  1'b1, 1'b1, 10, EST_PARADO,   0);
        addVetor("zero idle",     1'b1, 1'b0, 10, EST_PARADO,   1);
        addVetor("release zero",  1'b1, 1'b1, 10, EST_PARADO,   0);
        addVetor("start",         1'b0, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("release",       1'b1, 1'b1, 10, EST_CONTANDO, 0);
        addVetor("pause",         1'b0, 1'b1, 10, EST_PAUSADO,  0);
        addVetor("release",       1'b1, 1'b1, 10, EST_PAUSADO,  0);
        addVetor("zero paused",   1'b1, 1'b0, 10, EST_PARADO,   1);
        addVetor("release zero",  1'b1, 1'b1, 10, EST_PARADO,   0);
        addVetor("long hold",     1'b0, 1'b1, 30, EST_CONTANDO, 0);
        addVetor("release",       1'b1, 1'b1, 10, EST_CONTANDO, 0);

        foreach (tabela[k]) begin
            pulsos = zeroPulses;
            botaoIniciar = tabela[k].ini;
            botaoZerar = tabela[k].zer;
            repeat (tabela[k].ciclos) tick();
            check({"vector estado: ", tabela[k].nome}, 32'(estado), 32'(tabela[k].estadoEsp));
            check({"vector pulses: ", tabela[k].nome}, 32'(zeroPulses - pulsos), 32'(tabela[k].pulsosEsp));
            if (tabela[k].estadoEsp != EST_PAUSADO)
                check({"vector piscar: ", tabela[k].nome}, 32'(piscar), 32'(1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
